id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/forward_unit.sv | 42 ++++
 rtl/id_ex_stage.sv | 200 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the ID/EX pipeline slice.
// Holds the opcode constants, the forwarding-select encodings, the
// ID/EX state encodings and the per-cycle action encoding used by
// id_ex_stage and forward_unit.
package cpu_pkg;

  // Opcodes live in instr[15:12].
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LHB = 4'hA;
  localparam logic [3:0] OP_LLB = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operand source select.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // ID/EX stage state.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // What the EX registers do on the next rising edge.
  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2
  } action_e;

  function automatic logic is_hlt(input logic [15:0] instr);
    return instr[15:12] == OP_HLT;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand forward select for one ALU source.
// Ports:
//   ex_valid_i        - instruction in EX is real (not a bubble)
//   uses_i            - instruction in EX actually reads this operand
//   src_i             - register specifier of this operand in EX
//   exmem_regwrite_i  - EX/MEM instruction writes a register
//   exmem_rd_i        - EX/MEM destination
//   memwb_regwrite_i  - MEM/WB instruction writes a register
//   memwb_rd_i        - MEM/WB destination
//   sel_o             - FWD_MEM / FWD_WB / FWD_NONE
module forward_unit
  import cpu_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic             ex_valid_i,
  input  logic             uses_i,
  input  logic [REG_W-1:0] src_i,
  input  logic             exmem_regwrite_i,
  input  logic [REG_W-1:0] exmem_rd_i,
  input  logic             memwb_regwrite_i,
  input  logic [REG_W-1:0] memwb_rd_i,
  output logic [1:0]       sel_o
);

  logic mem_hit;
  logic wb_hit;

  // R0 is hardwired zero, so a write to it never produces a value to forward.
  assign mem_hit = exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i);
  assign wb_hit  = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i);

  always_comb begin
    sel_o = FWD_NONE;
    if (ex_valid_i && uses_i) begin
      // The younger producer (EX/MEM) holds the newer value.
      if (mem_hit)     sel_o = FWD_MEM;
      else if (wb_hit) sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, forward select,
// halt tracking and a flush/stall bubble counter.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   id_*                - decoded instruction from ID
//   ext_stall           - memory freeze: EX registers hold
//   flush               - taken branch in ID: insert a bubble
//   exmem_*/memwb_*     - downstream destinations for forwarding
//   ex_*                - registered copies of the ID fields
//   forward_a/forward_b - ALU operand source selects
//   load_use_stall      - freeze PC and IF/ID this cycle
//   halted              - HLT has been captured
//   bubble_count        - saturating count of flush/load-use bubbles
//   fsm_state           - current state (ST_RUN / ST_HALT)
// Handshake: there is no valid/ready pair here; id_valid qualifies the
// ID fields, and the stage accepts them on any edge whose action is
// CAPTURE. When load_use_stall is high the upstream must present the
// same instruction again on the following cycle.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [15:0]       id_instr,
  input  logic [DATA_W-1:0] id_regdata1,
  input  logic [DATA_W-1:0] id_regdata2,
  input  logic [DATA_W-1:0] id_pcs,
  input  logic              id_ldbyte,
  input  logic              id_memop,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_regwrite,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              ext_stall,
  input  logic              flush,
  input  logic              exmem_regwrite,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic              memwb_regwrite,
  input  logic [REG_W-1:0]  memwb_rd,
  output logic              ex_valid,
  output logic [15:0]       ex_instr,
  output logic [DATA_W-1:0] ex_regdata1,
  output logic [DATA_W-1:0] ex_regdata2,
  output logic [DATA_W-1:0] ex_pcs,
  output logic              ex_ldbyte,
  output logic              ex_memop,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_regwrite,
  output logic [REG_W-1:0]  ex_rd,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              load_use_stall,
  output logic              halted,
  output logic [15:0]       bubble_count,
  output logic [0:0]        fsm_state
);

  logic              valid_q, ldbyte_q, memop_q, memread_q, memwrite_q, regwrite_q;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] regdata1_q, regdata2_q, pcs_q;
  logic [REG_W-1:0]  rd_q, rs_q, rt_q;
  logic              uses_rs_q, uses_rt_q;
  logic [0:0]        state_q, state_d;
  logic [15:0]       bubble_count_q, bubble_count_d;
  action_e           action;
  logic              count_bubble;

  assign halted    = (state_q == ST_HALT);
  assign fsm_state = state_q;

  assign load_use_stall = !halted && id_valid && valid_q && memread_q && (rd_q != '0) &&
                          ((id_uses_rs && (id_rs == rd_q)) || (id_uses_rt && (id_rt == rd_q)));

  always_comb begin
    action       = ACT_CAPTURE;
    count_bubble = 1'b0;
    if (ext_stall) begin
      action = ACT_HOLD;
    end else if (halted) begin
      action = ACT_BUBBLE;
    end else if (flush || load_use_stall) begin
      // One bubble even when both causes coincide.
      action       = ACT_BUBBLE;
      count_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (action == ACT_CAPTURE && id_valid && is_hlt(id_instr)) state_d = ST_HALT;
  end

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (count_bubble && bubble_count_q != 16'hFFFF) bubble_count_d = bubble_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      bubble_count_q <= '0;
      valid_q        <= 1'b0;
      instr_q        <= '0;
      regdata1_q     <= '0;
      regdata2_q     <= '0;
      pcs_q          <= '0;
      ldbyte_q       <= 1'b0;
      memop_q        <= 1'b0;
      memread_q      <= 1'b0;
      memwrite_q     <= 1'b0;
      regwrite_q     <= 1'b0;
      rd_q           <= '0;
      rs_q           <= '0;
      rt_q           <= '0;
      uses_rs_q      <= 1'b0;
      uses_rt_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bubble_count_q <= bubble_count_d;
      case (action)
        ACT_CAPTURE: begin
          valid_q    <= id_valid;
          instr_q    <= id_instr;
          regdata1_q <= id_regdata1;
          regdata2_q <= id_regdata2;
          pcs_q      <= id_pcs;
          ldbyte_q   <= id_ldbyte;
          memop_q    <= id_memop;
          memread_q  <= id_memread;
          memwrite_q <= id_memwrite;
          regwrite_q <= id_regwrite;
          rd_q       <= id_rd;
          rs_q       <= id_rs;
          rt_q       <= id_rt;
          uses_rs_q  <= id_uses_rs;
          uses_rt_q  <= id_uses_rt;
        end
        ACT_BUBBLE: begin
          // Bubble is ADD R0,R0,R0 with no side effects; data fields keep old values.
          valid_q    <= 1'b0;
          instr_q    <= '0;
          ldbyte_q   <= 1'b0;
          memop_q    <= 1'b0;
          memread_q  <= 1'b0;
          memwrite_q <= 1'b0;
          regwrite_q <= 1'b0;
          rd_q       <= '0;
          uses_rs_q  <= 1'b0;
          uses_rt_q  <= 1'b0;
        end
        default: ; // ACT_HOLD: everything keeps its value
      endcase
    end
  end

  forward_unit #(.REG_W(REG_W)) u_fwd_a (
    .ex_valid_i      (valid_q),
    .uses_i          (uses_rs_q),
    .src_i           (rs_q),
    .exmem_regwrite_i(exmem_regwrite),
    .exmem_rd_i      (exmem_rd),
    .memwb_regwrite_i(memwb_regwrite),
    .memwb_rd_i      (memwb_rd),
    .sel_o           (forward_a)
  );

  forward_unit #(.REG_W(REG_W)) u_fwd_b (
    .ex_valid_i      (valid_q),
    .uses_i          (uses_rt_q),
    .src_i           (rt_q),
    .exmem_regwrite_i(exmem_regwrite),
    .exmem_rd_i      (exmem_rd),
    .memwb_regwrite_i(memwb_regwrite),
    .memwb_rd_i      (memwb_rd),
    .sel_o           (forward_b)
  );

  assign ex_valid     = valid_q;
  assign ex_instr     = instr_q;
  assign ex_regdata1  = regdata1_q;
  assign ex_regdata2  = regdata2_q;
  assign ex_pcs       = pcs_q;
  assign ex_ldbyte    = ldbyte_q;
  assign ex_memop     = memop_q;
  assign ex_memread   = memread_q;
  assign ex_memwrite  = memwrite_q;
  assign ex_regwrite  = regwrite_q;
  assign ex_rd        = rd_q;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [15:0] id_instr, id_regdata1, id_regdata2, id_pcs;
  logic        id_ldbyte, id_memop, id_memread, id_memwrite, id_regwrite;
  logic        id_uses_rs, id_uses_rt;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic        ext_stall, flush;
  logic        exmem_regwrite, memwb_regwrite;
  logic [3:0]  exmem_rd, memwb_rd;
  logic        ex_valid, ex_ldbyte, ex_memop, ex_memread, ex_memwrite, ex_regwrite;
  logic [15:0] ex_instr, ex_regdata1, ex_regdata2, ex_pcs;
  logic [3:0]  ex_rd;
  logic [1:0]  forward_a, forward_b;
  logic        load_use_stall, halted;
  logic [15:0] bubble_count;
  logic [0:0]  fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_instr(id_instr), .id_regdata1(id_regdata1),
    .id_regdata2(id_regdata2), .id_pcs(id_pcs), .id_ldbyte(id_ldbyte),
    .id_memop(id_memop), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_regwrite(id_regwrite), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ext_stall(ext_stall), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_regdata1(ex_regdata1),
    .ex_regdata2(ex_regdata2), .ex_pcs(ex_pcs), .ex_ldbyte(ex_ldbyte),
    .ex_memop(ex_memop), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .forward_a(forward_a), .forward_b(forward_b),
    .load_use_stall(load_use_stall), .halted(halted),
    .bubble_count(bubble_count), .fsm_state(fsm_state)
  );

  // ---------------- vector record ----------------
  typedef struct {
    logic        valid;
    logic [15:0] instr;
    logic        memread;
    logic        uses_rs, uses_rt;
    logic [3:0]  rs, rt, rd;
    logic        flush, stall;
    logic        xm_rw;
    logic [3:0]  xm_rd;
    logic        mw_rw;
    logic [3:0]  mw_rd;
    logic        e_lus;      // checked before the edge
    logic        e_valid;    // the rest checked after the edge
    logic [15:0] e_instr;
    logic [3:0]  e_rd;
    logic        e_halted;
    logic [15:0] e_bc;
    logic [1:0]  e_fa, e_fb;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_valid = 1'b0; id_instr = '0; id_regdata1 = '0; id_regdata2 = '0; id_pcs = '0;
    id_ldbyte = 1'b0; id_memop = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
    id_regwrite = 1'b0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    ext_stall = 1'b0; flush = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = '0; memwb_regwrite = 1'b0; memwb_rd = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    id_valid = v.valid; id_instr = v.instr; id_memread = v.memread;
    id_memop = v.memread; id_regwrite = v.valid;
    id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    flush = v.flush; ext_stall = v.stall;
    exmem_regwrite = v.xm_rw; exmem_rd = v.xm_rd;
    memwb_regwrite = v.mw_rw; memwb_rd = v.mw_rd;
  endtask

  task automatic add(input vec_t v);
    vecs.push_back(v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;

    // valid instr mr urs urt rs rt rd fl st xmrw xmrd mwrw mwrd | lus ev einstr erd eh ebc fa fb
    add('{1, 16'h0312, 0, 1, 1, 4'd1, 4'd2, 4'd3, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 16'h0312, 4'd3, 0, 16'd0, 2'b00, 2'b00});
    add('{1, 16'h0431, 0, 1, 1, 4'd3, 4'd1, 4'd4, 0, 0, 1, 4'd3, 0, 4'd0, 0, 1, 16'h0431, 4'd4, 0, 16'd0, 2'b10, 2'b00});
    add('{1, 16'h0675, 0, 1, 1, 4'd7, 4'd5, 4'd6, 0, 0, 1, 4'd5, 1, 4'd5, 0, 1, 16'h0675, 4'd6, 0, 16'd0, 2'b00, 2'b10});
    add('{1, 16'h0675, 0, 1, 1, 4'd7, 4'd5, 4'd6, 0, 0, 1, 4'd0, 1, 4'd0, 0, 1, 16'h0675, 4'd6, 0, 16'd0, 2'b00, 2'b00});
    add('{1, 16'h0675, 0, 1, 1, 4'd7, 4'd5, 4'd6, 0, 0, 1, 4'd9, 1, 4'd7, 0, 1, 16'h0675, 4'd6, 0, 16'd0, 2'b01, 2'b00});
    add('{1, 16'h0675, 0, 1, 0, 4'd7, 4'd5, 4'd6, 0, 0, 1, 4'd5, 1, 4'd5, 0, 1, 16'h0675, 4'd6, 0, 16'd0, 2'b00, 2'b00});
    add('{1, 16'h8210, 1, 1, 0, 4'd1, 4'd0, 4'd2, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 16'h8210, 4'd2, 0, 16'd0, 2'b00, 2'b00});
    add('{1, 16'h0523, 0, 1, 1, 4'd2, 4'd3, 4'd5, 0, 0, 0, 4'd0, 0, 4'd0, 1, 0, 16'h0000, 4'd0, 0, 16'd1, 2'b00, 2'b00});
    add('{1, 16'h0523, 0, 1, 1, 4'd2, 4'd3, 4'd5, 0, 0, 1, 4'd2, 0, 4'd0, 0, 1, 16'h0523, 4'd5, 0, 16'd1, 2'b10, 2'b00});
    add('{1, 16'h8430, 1, 1, 0, 4'd3, 4'd0, 4'd4, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 16'h8430, 4'd4, 0, 16'd1, 2'b00, 2'b00});
    add('{1, 16'h0104, 0, 1, 1, 4'd0, 4'd4, 4'd1, 0, 0, 0, 4'd0, 0, 4'd0, 1, 0, 16'h0000, 4'd0, 0, 16'd2, 2'b00, 2'b00});
    add('{1, 16'h8430, 1, 1, 0, 4'd3, 4'd0, 4'd4, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 16'h8430, 4'd4, 0, 16'd2, 2'b00, 2'b00});
    add('{1, 16'h0104, 0, 1, 1, 4'd0, 4'd4, 4'd1, 1, 0, 0, 4'd0, 0, 4'd0, 1, 0, 16'h0000, 4'd0, 0, 16'd3, 2'b00, 2'b00});
    add('{1, 16'h0777, 0, 1, 1, 4'd7, 4'd7, 4'd7, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 16'h0777, 4'd7, 0, 16'd3, 2'b00, 2'b00});
    add('{1, 16'h0888, 0, 1, 1, 4'd8, 4'd8, 4'd8, 1, 1, 0, 4'd0, 0, 4'd0, 0, 1, 16'h0777, 4'd7, 0, 16'd3, 2'b00, 2'b00});
    add('{1, 16'h0888, 0, 1, 1, 4'd8, 4'd8, 4'd8, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 16'h0000, 4'd0, 0, 16'd4, 2'b00, 2'b00});
    add('{1, 16'hF000, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 16'hF000, 4'd0, 1, 16'd4, 2'b00, 2'b00});
    add('{1, 16'h0312, 0, 1, 1, 4'd1, 4'd2, 4'd3, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 16'h0000, 4'd0, 1, 16'd4, 2'b00, 2'b00});
    add('{1, 16'h0312, 0, 1, 1, 4'd1, 4'd2, 4'd3, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 16'h0000, 4'd0, 1, 16'd4, 2'b00, 2'b00});
    add('{1, 16'h0312, 0, 1, 1, 4'd1, 4'd2, 4'd3, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 16'h0000, 4'd0, 1, 16'd4, 2'b00, 2'b00});

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_instr", ex_instr, 16'h0000);
    check("rst_halted", halted, 0);
    check("rst_bubble_count", bubble_count, 0);
    check("rst_state", fsm_state, 0);
    check("rst_fwd_a", forward_a, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // ---- table ----
    foreach (vecs[i]) begin
      drive_vec(vecs[i]);
      #1;
      check($sformatf("v%0d_lus", i), load_use_stall, vecs[i].e_lus);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ex_valid", i), ex_valid, vecs[i].e_valid);
      check($sformatf("v%0d_ex_instr", i), ex_instr, vecs[i].e_instr);
      check($sformatf("v%0d_ex_rd", i), ex_rd, vecs[i].e_rd);
      check($sformatf("v%0d_halted", i), halted, vecs[i].e_halted);
      check($sformatf("v%0d_bubble_count", i), bubble_count, vecs[i].e_bc);
      check($sformatf("v%0d_fwd_a", i), forward_a, vecs[i].e_fa);
      check($sformatf("v%0d_fwd_b", i), forward_b, vecs[i].e_fb);
      @(negedge clk);
    end

    // ---- reset while halted, with ext_stall also high ----
    idle_inputs();
    ext_stall = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("halt_rst_halted", halted, 0);
    check("halt_rst_state", fsm_state, 0);
    check("halt_rst_bubble_count", bubble_count, 0);
    @(negedge clk);
    rst = 1'b0;
    ext_stall = 1'b0;

    // ---- full datapath capture ----
    id_valid = 1'b1; id_instr = 16'h9ABC; id_regdata1 = 16'hBEEF; id_regdata2 = 16'h1234;
    id_pcs = 16'h0042; id_ldbyte = 1'b1; id_memop = 1'b1; id_memwrite = 1'b1;
    id_regwrite = 1'b1; id_rd = 4'hC;
    @(posedge clk); #1;
    check("dp_valid", ex_valid, 1);
    check("dp_instr", ex_instr, 16'h9ABC);
    check("dp_regdata1", ex_regdata1, 16'hBEEF);
    check("dp_regdata2", ex_regdata2, 16'h1234);
    check("dp_pcs", ex_pcs, 16'h0042);
    check("dp_ldbyte", ex_ldbyte, 1);
    check("dp_memop", ex_memop, 1);
    check("dp_memwrite", ex_memwrite, 1);
    check("dp_regwrite", ex_regwrite, 1);
    check("dp_memread", ex_memread, 0);
    check("dp_rd", ex_rd, 4'hC);
    check("dp_state_run", fsm_state, 0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    check("fl_valid", ex_valid, 0);
    check("fl_ldbyte", ex_ldbyte, 0);
    check("fl_memop", ex_memop, 0);
    check("fl_memwrite", ex_memwrite, 0);
    check("fl_regwrite", ex_regwrite, 0);
    check("fl_rd", ex_rd, 0);
    check("fl_bubble_count", bubble_count, 1);
    @(negedge clk);
    flush = 1'b0;
    id_instr = 16'h8210; id_memread = 1'b1; id_memwrite = 1'b0; id_rd = 4'h2;
    @(posedge clk); #1;
    check("lw_memread", ex_memread, 1);
    @(negedge clk);
    // Reset during a memory freeze clears everything.
    ext_stall = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("stall_rst_valid", ex_valid, 0);
    check("stall_rst_memread", ex_memread, 0);
    check("stall_rst_bubble_count", bubble_count, 0);
    @(negedge clk);
    rst = 1'b0;
    ext_stall = 1'b0;

    // ---- bubble counter saturation ----
    idle_inputs();
    flush = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("sat_reach", bubble_count, 16'hFFFF);
    @(posedge clk); #1;
    check("sat_hold", bubble_count, 16'hFFFF);
    @(negedge clk);
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
